pci_rd_fifo: RTL and testbench



---
 rtl/pci_fifo_pkg.sv | 10 +
 rtl/pci_fifo_ram.sv | 26 ++
 rtl/pci_rd_fifo.sv | 115 +++++++++++
 tb/tb_pci_rd_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pci_fifo_pkg.sv
// Shared constants and types for the PCI read-side receive FIFO.
package pci_fifo_pkg;

    localparam int PCI_FIFO_DATA_W = 32;
    localparam int PCI_FIFO_DEPTH  = 16;

    // Occupancy needs one bit more than the pointers so that it can hold DEPTH itself.
    typedef logic [$clog2(PCI_FIFO_DEPTH):0] pci_fifo_level_t;

endpackage

// File: rtl/pci_fifo_ram.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port, no reset.
module pci_fifo_ram
    import pci_fifo_pkg::*;
#(
    parameter int DATA_W = PCI_FIFO_DATA_W,
    parameter int DEPTH  = PCI_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pci_rd_fifo.sv
// Receive FIFO between the PCI core read interface and a valid/ready host consumer.
// Sticky overflow flag and err_clr exist only when PCI_RD_FIFO_ERR_EN is defined.
module pci_rd_fifo
    import pci_fifo_pkg::*;
#(
    parameter int DATA_W    = PCI_FIFO_DATA_W,
    parameter int DEPTH     = PCI_FIFO_DEPTH,
    parameter int AF_THRESH = 12
) (
    input  logic                   pclk,
    input  logic                   pci_rst,
    input  logic                   read_push,
    input  logic [DATA_W-1:0]      read_data,
    output logic                   read_full,
    output logic                   read_afull,
    output logic                   host_rd_valid,
    input  logic                   host_rd_ready,
    output logic [DATA_W-1:0]      host_rd_data,
    output logic [$clog2(DEPTH):0] level,
`ifdef PCI_RD_FIFO_ERR_EN
    input  logic                   err_clr,
    output logic                   overflow,
`endif
    input  logic                   flush
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Handshake: a word moves to the host on any rising edge where
    // host_rd_valid and host_rd_ready are both high; valid never depends on ready.
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_next;
    logic          full_q;
    logic          afull_q;
    logic          valid_q;
    logic          push_ok;
    logic          pop_ok;

    // Acceptance is judged on the pre-edge level, so a pop in the same cycle
    // never makes room for a push into a full FIFO.
    assign push_ok = read_push && (level_q != LW'(DEPTH));
    assign pop_ok  = valid_q && host_rd_ready;

    always_comb begin
        level_next = level_q;
        if (flush) begin
            level_next = '0;
        end else if (push_ok && !pop_ok) begin
            level_next = level_q + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_next = level_q - LW'(1);
        end
    end

    always_ff @(posedge pclk or posedge pci_rst) begin
        if (pci_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            end
            level_q <= level_next;
            full_q  <= (level_next == LW'(DEPTH));
            afull_q <= (level_next >= LW'(AF_THRESH));
            valid_q <= (level_next != '0);
        end
    end

`ifdef PCI_RD_FIFO_ERR_EN
    logic overflow_q;

    // A new drop outranks a simultaneous clear; a flushed push is never flagged.
    always_ff @(posedge pclk or posedge pci_rst) begin
        if (pci_rst) begin
            overflow_q <= 1'b0;
        end else if (!flush && read_push && (level_q == LW'(DEPTH))) begin
            overflow_q <= 1'b1;
        end else if (err_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow = overflow_q;
`endif

    pci_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (pclk),
        .we    (push_ok && !flush),
        .waddr (wr_ptr),
        .wdata (read_data),
        .raddr (rd_ptr),
        .rdata (host_rd_data)
    );

    assign level         = level_q;
    assign read_full     = full_q;
    assign read_afull    = afull_q;
    assign host_rd_valid = valid_q;

endmodule

// File: tb/tb_pci_rd_fifo.sv
// Directed bench for pci_rd_fifo: queue-based reference model plus literal spot checks.
// Overflow/err_clr checks are built only when PCI_RD_FIFO_ERR_EN is defined.
module tb_pci_rd_fifo;
    import pci_fifo_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic            pclk = 1'b0;
    logic            pci_rst = 1'b1;
    logic            read_push = 1'b0;
    logic [DW-1:0]   read_data = '0;
    logic            read_full;
    logic            read_afull;
    logic            host_rd_valid;
    logic            host_rd_ready = 1'b0;
    logic [DW-1:0]   host_rd_data;
    pci_fifo_level_t level;
    logic            flush = 1'b0;
    logic            err_clr = 1'b0;
    logic            overflow;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic          m_ovf = 1'b0;

    always #5 pclk = ~pclk;

    pci_rd_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .pclk          (pclk),
        .pci_rst       (pci_rst),
        .read_push     (read_push),
        .read_data     (read_data),
        .read_full     (read_full),
        .read_afull    (read_afull),
        .host_rd_valid (host_rd_valid),
        .host_rd_ready (host_rd_ready),
        .host_rd_data  (host_rd_data),
        .level         (level),
`ifdef PCI_RD_FIFO_ERR_EN
        .err_clr       (err_clr),
        .overflow      (overflow),
`endif
        .flush         (flush)
    );

`ifndef PCI_RD_FIFO_ERR_EN
    assign overflow = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain word queue updated from the rules of acceptance.
    always @(posedge pclk or posedge pci_rst) begin
        if (pci_rst) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            int  n;
            bit  do_push;
            bit  do_pop;
            n       = exp_q.size();
            do_push = read_push && (n < DEPTH);
            do_pop  = host_rd_ready && (n > 0);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (do_pop)  void'(exp_q.pop_front());
                if (do_push) exp_q.push_back(read_data);
            end
            if (!flush && read_push && n == DEPTH) m_ovf = 1'b1;
            else if (err_clr) m_ovf = 1'b0;
        end
    end

    always @(negedge pclk) begin
        int n;
        n = exp_q.size();
        check("model_level", 32'(level), 32'(n));
        check("model_valid", 32'(host_rd_valid), 32'(n > 0));
        check("model_full",  32'(read_full), 32'(n == DEPTH));
        check("model_afull", 32'(read_afull), 32'(n >= AF));
        if (n > 0) check("model_data", host_rd_data, exp_q[0]);
`ifdef PCI_RD_FIFO_ERR_EN
        check("model_ovf", 32'(overflow), 32'(m_ovf));
`endif
    end

    // Apply inputs at a falling edge and return at the next falling edge.
    task automatic step(input bit push, input logic [DW-1:0] d, input bit rdy,
                        input bit fl = 1'b0, input bit clr = 1'b0);
        read_push     = push;
        read_data     = d;
        host_rd_ready = rdy;
        flush         = fl;
        err_clr       = clr;
        @(negedge pclk);
        read_push     = 1'b0;
        host_rd_ready = 1'b0;
        flush         = 1'b0;
        err_clr       = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(host_rd_valid), 0);
        check("rst_full",  32'(read_full), 0);
        check("rst_afull", 32'(read_afull), 0);
        check("rst_ovf",   32'(overflow), 0);
        pci_rst = 1'b0;
        @(negedge pclk);

        step(1, 32'hA5A5_0001, 0);
        check("first_valid", 32'(host_rd_valid), 1);
        check("first_level", 32'(level), 1);
        check("first_data",  host_rd_data, 32'hA5A5_0001);
        step(0, 0, 1);
        check("first_pop_level", 32'(level), 0);

        for (int i = 0; i < 16; i++) begin
            step(1, 32'(i), 0);
            check("fill_afull", 32'(read_afull), 32'(i + 1 >= 12));
            check("fill_full",  32'(read_full),  32'(i + 1 == 16));
        end
        step(1, 32'hDEAD_BEEF, 0);
        check("ovf_level", 32'(level), 16);
`ifdef PCI_RD_FIFO_ERR_EN
        check("ovf_flag", 32'(overflow), 1);
`endif
        for (int i = 0; i < 16; i++) begin
            check("drain_data", host_rd_data, 32'(i));
            step(0, 0, 1);
        end
        check("drain_level", 32'(level), 0);

        step(1, 32'h100, 1);
        check("pp_empty_level", 32'(level), 1);
        check("pp_empty_data", host_rd_data, 32'h100);
        for (int i = 1; i < 5; i++) step(1, 32'h100 + 32'(i), 0);
        check("lvl5", 32'(level), 5);
        step(1, 32'h105, 1);
        check("pp5_level", 32'(level), 5);
        check("pp5_data", host_rd_data, 32'h101);
        for (int i = 6; i < 17; i++) step(1, 32'h100 + 32'(i), 0);
        check("lvl16", 32'(level), 16);
        step(1, 32'h0BAD_0BAD, 1);
        check("pp16_level", 32'(level), 15);
        check("pp16_data", host_rd_data, 32'h102);

        repeat (6) step(0, 0, 1);
        check("lvl9", 32'(level), 9);
        step(1, 32'h5555_5555, 1, 1);
        check("flush_level", 32'(level), 0);
        check("flush_valid", 32'(host_rd_valid), 0);
`ifdef PCI_RD_FIFO_ERR_EN
        check("flush_ovf_kept", 32'(overflow), 1);
        for (int i = 0; i < 16; i++) step(1, 32'h200 + 32'(i), 0);
        step(1, 32'h0000_0BAD, 0, 0, 1);
        check("clr_vs_set", 32'(overflow), 1);
        step(0, 0, 0, 0, 1);
        check("clr_alone", 32'(overflow), 0);
        step(0, 0, 0, 1);
`endif

        for (int i = 0; i < 3; i++) step(1, 32'h1000 + 32'(i), 0);
        for (int i = 0; i < 40; i++) begin
            check("wrap_data", host_rd_data, 32'h1000 + 32'(i));
            step(1, 32'h1000 + 32'(i + 3), 1);
            check("wrap_level", 32'(level), 3);
        end
        check("wrap_full", 32'(read_full), 0);
        check("wrap_afull", 32'(read_afull), 0);
        check("wrap_ovf", 32'(overflow), 0);

        for (int i = 0; i < 5; i++) step(1, 32'h3000 + 32'(i), 0);
        #2 pci_rst = 1'b1;
        #1;
        check("async_rst_level", 32'(level), 0);
        check("async_rst_valid", 32'(host_rd_valid), 0);
        @(negedge pclk);
        pci_rst = 1'b0;
        step(1, 32'h4000_0001, 0);
        check("post_rst_level", 32'(level), 1);
        check("post_rst_data", host_rd_data, 32'h4000_0001);

        repeat (2) @(negedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
